trx_sequencer: RTL and testbench

//  T/R sequencer for the transceiver datapath. Sequences the AD9866 device reset after power-up.

---
 rtl/trx_seq_pkg.sv | 34 +++
 rtl/seq_timer.sv | 28 ++
 rtl/trx_sequencer.sv | 111 +++++++++++
 tb/tb_trx_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trx_seq_pkg.sv
// Shared state codes and default guard-interval lengths for the T/R sequencer.
// State codes are visible on the status register, so their values are fixed.
package trx_seq_pkg;

  typedef enum logic [3:0] {
    S_HWRST     = 4'd0,
    S_INIT      = 4'd1,
    S_RX        = 4'd2,
    S_RX_OFF    = 4'd3,
    S_KEY       = 4'd4,
    S_TX        = 4'd5,
    S_UNKEY     = 4'd6,
    S_RELAY_OFF = 4'd7
  } state_t;

  localparam int unsigned DEF_RESET_CYCLES = 64;
  localparam int unsigned DEF_INIT_CYCLES  = 1024;
  localparam int unsigned DEF_MUTE_CYCLES  = 256;
  localparam int unsigned DEF_RELAY_CYCLES = 7373;
  localparam int unsigned DEF_DRAIN_CYCLES = 512;

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d,
                                             input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down counter that times each sequencer state.
// It stops at zero so untimed states can leave it idle without wrapping.
module seq_timer #(
  parameter int unsigned    TW          = 8,
  parameter logic [TW-1:0]  RESET_VALUE = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/trx_sequencer.sv
// AD9866 T/R sequencer: device reset after power-up, then RX <-> TX switching
// with guard intervals so the PA never hot-switches the antenna relay.
module trx_sequencer
  import trx_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int unsigned MUTE_CYCLES  = DEF_MUTE_CYCLES,
  parameter int unsigned RELAY_CYCLES = DEF_RELAY_CYCLES,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       soft_reset,
  input  logic       ptt_req,
  input  logic       tx_allow,
  input  logic       loopback_req,
  output logic       dev_reset,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       loopback,
  output logic       relay,
  output logic       tx_active,
  output logic [3:0] state
);

  localparam int unsigned TW = $clog2(max_cycles(RESET_CYCLES, INIT_CYCLES, MUTE_CYCLES,
                                                 RELAY_CYCLES, DRAIN_CYCLES)) + 1;

  localparam logic [TW-1:0] LOAD_RESET = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] LOAD_INIT  = TW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] LOAD_MUTE  = TW'(MUTE_CYCLES - 1);
  localparam logic [TW-1:0] LOAD_RELAY = TW'(RELAY_CYCLES - 1);
  localparam logic [TW-1:0] LOAD_DRAIN = TW'(DRAIN_CYCLES - 1);

  state_t        seq_state;
  state_t        next_state;
  logic          load;
  logic [TW-1:0] load_value;
  logic          expired;

  seq_timer #(
    .TW          (TW),
    .RESET_VALUE (LOAD_RESET)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .value (load_value),
    .zero  (expired)
  );

  always_comb begin
    next_state = seq_state;
    load_value = '0;
    case (seq_state)
      S_HWRST:     if (expired) next_state = S_INIT;
      S_INIT:      if (expired) next_state = S_RX;
      S_RX:        if (ptt_req && tx_allow) next_state = S_RX_OFF;
      S_RX_OFF: begin
        if (!ptt_req)     next_state = S_RX;
        else if (expired) next_state = S_KEY;
      end
      S_KEY: begin
        if (!ptt_req)     next_state = S_RELAY_OFF;
        else if (expired) next_state = S_TX;
      end
      S_TX:        if (!ptt_req || !tx_allow) next_state = S_UNKEY;
      S_UNKEY:     if (expired) next_state = S_RELAY_OFF;
      S_RELAY_OFF: if (expired) next_state = S_RX;
      default:     next_state = S_HWRST;
    endcase
    // Soft reset overrides everything and always reloads, even from S_HWRST.
    if (soft_reset) next_state = S_HWRST;
    load = soft_reset || (next_state != seq_state);
    case (next_state)
      S_HWRST:     load_value = LOAD_RESET;
      S_INIT:      load_value = LOAD_INIT;
      S_RX_OFF:    load_value = LOAD_MUTE;
      S_KEY:       load_value = loopback ? '0 : LOAD_RELAY;
      S_UNKEY:     load_value = LOAD_DRAIN;
      S_RELAY_OFF: load_value = loopback ? '0 : LOAD_RELAY;
      default:     load_value = '0;
    endcase
  end

  // Enables rise one cycle after their state settles but drop on the exit edge,
  // so a codec enable is never live across a transition.
  always_ff @(posedge clock) begin
    if (!reset) begin
      seq_state <= S_HWRST;
      dev_reset <= 1'b1;
      rx_enable <= 1'b0;
      tx_enable <= 1'b0;
      relay     <= 1'b0;
      loopback  <= 1'b0;
      tx_active <= 1'b0;
    end else begin
      seq_state <= next_state;
      dev_reset <= (next_state == S_HWRST);
      rx_enable <= (seq_state == S_RX) && (next_state == S_RX);
      tx_enable <= (seq_state == S_TX) && (next_state == S_TX);
      relay     <= !loopback && (next_state inside {S_KEY, S_TX, S_UNKEY});
      tx_active <= (next_state inside {S_KEY, S_TX, S_UNKEY});
      if (seq_state == S_RX) loopback <= loopback_req;
    end
  end

  assign state = seq_state;

endmodule

// File: tb/tb_trx_sequencer.sv
// Bench for trx_sequencer: directed latency steps plus a randomized run,
// all compared against a phase/deadline model of the sequencer.
module tb_trx_sequencer;

  localparam int P_RESET = 4;
  localparam int P_INIT  = 8;
  localparam int P_MUTE  = 3;
  localparam int P_RELAY = 5;
  localparam int P_DRAIN = 2;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       ptt_req;
  logic       tx_allow;
  logic       loopback_req;
  logic       dev_reset;
  logic       rx_enable;
  logic       tx_enable;
  logic       loopback;
  logic       relay;
  logic       tx_active;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   m_phase = 0;
  int   m_entry = 0;
  logic m_lb    = 1'b0;

  logic saw_relay, saw_tx, saw_no_lb;

  trx_sequencer #(
    .RESET_CYCLES (P_RESET),
    .INIT_CYCLES  (P_INIT),
    .MUTE_CYCLES  (P_MUTE),
    .RELAY_CYCLES (P_RELAY),
    .DRAIN_CYCLES (P_DRAIN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .soft_reset   (soft_reset),
    .ptt_req      (ptt_req),
    .tx_allow     (tx_allow),
    .loopback_req (loopback_req),
    .dev_reset    (dev_reset),
    .rx_enable    (rx_enable),
    .tx_enable    (tx_enable),
    .loopback     (loopback),
    .relay        (relay),
    .tx_active    (tx_active),
    .state        (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Phase lengths in cycles; 0 means the phase waits on inputs only.
  function automatic int dur(input int ph, input logic lb);
    case (ph)
      0: return P_RESET;
      1: return P_INIT;
      3: return P_MUTE;
      4: return lb ? 1 : P_RELAY;
      6: return P_DRAIN;
      7: return lb ? 1 : P_RELAY;
      default: return 0;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs held over it.
  task automatic model_step();
    int  old_ph;
    int  nxt;
    bit  done;
    cyc++;
    if (!reset) begin
      m_phase = 0;
      m_entry = cyc;
      m_lb    = 1'b0;
    end else begin
      old_ph = m_phase;
      nxt    = old_ph;
      done   = (dur(old_ph, m_lb) != 0) && (cyc == m_entry + dur(old_ph, m_lb));
      case (old_ph)
        0: if (done) nxt = 1;
        1: if (done) nxt = 2;
        2: if (ptt_req && tx_allow) nxt = 3;
        3: if (!ptt_req) nxt = 2; else if (done) nxt = 4;
        4: if (!ptt_req) nxt = 7; else if (done) nxt = 5;
        5: if (!ptt_req || !tx_allow) nxt = 6;
        6: if (done) nxt = 7;
        7: if (done) nxt = 2;
        default: nxt = 0;
      endcase
      if (soft_reset) nxt = 0;
      if (nxt != old_ph || soft_reset) m_entry = cyc;
      if (old_ph == 2) m_lb = loopback_req;
      m_phase = nxt;
    end
  endtask

  task automatic tick();
    logic [3:0] ph;
    @(posedge clock);
    model_step();
    @(negedge clock);
    ph = m_phase[3:0];
    chk("state",     state,     ph);
    chk("dev_reset", dev_reset, m_phase == 0);
    chk("rx_enable", rx_enable, (m_phase == 2) && (cyc > m_entry));
    chk("tx_enable", tx_enable, (m_phase == 5) && (cyc > m_entry));
    chk("relay",     relay,     (m_phase >= 4) && (m_phase <= 6) && !m_lb);
    chk("tx_active", tx_active, (m_phase >= 4) && (m_phase <= 6));
    chk("loopback",  loopback,  m_lb);
    if (relay === 1'b1)     saw_relay = 1'b1;
    if (tx_enable === 1'b1) saw_tx    = 1'b1;
    if (loopback !== 1'b1)  saw_no_lb = 1'b1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      1: return rx_enable;
      2: return tx_enable;
      3: return relay;
      default: return dev_reset;
    endcase
  endfunction

  // Tick until the chosen output shows val; hit is the cycle or -1 on timeout.
  task automatic run_until(input int which, input logic val, input int limit, output int hit);
    hit = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (sig(which) === val) begin
        hit = cyc;
        return;
      end
    end
  endtask

  initial begin
    int t0, k, j, a, s0, hit;
    reset = 1'b0; soft_reset = 1'b0; ptt_req = 1'b0; tx_allow = 1'b1; loopback_req = 1'b0;
    saw_relay = 1'b0; saw_tx = 1'b0; saw_no_lb = 1'b0;

    // Power-up: release reset during cycle t0, RX enable comes at t0+13.
    repeat (3) tick();
    t0 = cyc;
    reset = 1'b1;
    run_until(1, 1'b1, 40, hit);
    chk("rx_after_reset", hit, t0 + 13);
    chk("state_after_reset", state, 4'd2);
    repeat (3) tick();

    // Full key/unkey cycle.
    ptt_req = 1'b1; k = cyc;
    run_until(1, 1'b0, 10, hit);  chk("ptt_rx_off", hit, k + 1);
    run_until(3, 1'b1, 10, hit);  chk("ptt_relay_on", hit, k + 1 + P_MUTE);
    run_until(2, 1'b1, 20, hit);  chk("ptt_tx_on", hit, k + 1 + P_MUTE + P_RELAY + 1);
    repeat (4) tick();
    ptt_req = 1'b0; j = cyc;
    run_until(2, 1'b0, 10, hit);  chk("unkey_tx_off", hit, j + 1);
    run_until(3, 1'b0, 10, hit);  chk("unkey_relay_off", hit, j + 1 + P_DRAIN);
    run_until(1, 1'b1, 20, hit);  chk("unkey_rx_on", hit, j + 2 + P_DRAIN + P_RELAY);
    repeat (2) tick();

    // Two-cycle ptt pulse aborts during the mute interval.
    saw_relay = 1'b0; saw_tx = 1'b0;
    ptt_req = 1'b1;
    repeat (2) tick();
    ptt_req = 1'b0;
    repeat (12) tick();
    chk("pulse_no_relay", saw_relay, 1'b0);
    chk("pulse_no_tx", saw_tx, 1'b0);
    chk("pulse_back_rx", state, 4'd2);

    // tx_allow drop while transmitting forces an unwind with ptt still held.
    ptt_req = 1'b1;
    run_until(2, 1'b1, 30, hit);
    tx_allow = 1'b0; a = cyc;
    run_until(2, 1'b0, 10, hit);  chk("inhibit_tx_off", hit, a + 1);
    saw_tx = 1'b0;
    repeat (25) tick();
    chk("inhibit_no_rekey", saw_tx, 1'b0);
    chk("inhibit_rx_state", state, 4'd2);
    chk("inhibit_rx_on", rx_enable, 1'b1);
    ptt_req = 1'b0;
    tick();
    tx_allow = 1'b1;
    repeat (3) tick();

    // Digital loopback: no relay, short key/unkey guards.
    loopback_req = 1'b1;
    repeat (2) tick();
    saw_relay = 1'b0; saw_no_lb = 1'b0;
    ptt_req = 1'b1; k = cyc;
    run_until(2, 1'b1, 20, hit);  chk("lb_tx_on", hit, k + 1 + P_MUTE + 1 + 1);
    repeat (3) tick();
    ptt_req = 1'b0; j = cyc;
    run_until(1, 1'b1, 20, hit);  chk("lb_rx_on", hit, j + 2 + P_DRAIN + 1);
    chk("lb_no_relay", saw_relay, 1'b0);
    chk("lb_held", saw_no_lb, 1'b0);
    loopback_req = 1'b0;
    repeat (3) tick();

    // Soft reset while transmitting drops everything on the next cycle.
    ptt_req = 1'b1;
    run_until(2, 1'b1, 30, hit);
    soft_reset = 1'b1; s0 = cyc;
    tick();
    soft_reset = 1'b0; ptt_req = 1'b0;
    chk("soft_state", state, 4'd0);
    chk("soft_dev_reset", dev_reset, 1'b1);
    chk("soft_tx", tx_enable, 1'b0);
    chk("soft_relay", relay, 1'b0);
    chk("soft_rx", rx_enable, 1'b0);
    run_until(1, 1'b1, 40, hit);  chk("soft_reinit_rx", hit, s0 + 14);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) ptt_req = ~ptt_req;
      if ($urandom_range(49) == 0) tx_allow = ~tx_allow;
      if ($urandom_range(29) == 0) loopback_req = ~loopback_req;
      soft_reset = ($urandom_range(399) == 0);
      reset      = ($urandom_range(799) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
